// File: rtl/arbitro_selector_if.sv
// arbitro_selector_if: request/select bundle between requesters and the arbiter.
//   solicitud1, solicitud2 : level-sensitive requests for mux inputs X and Y
//   selector[1:0]          : 01 selects X, 10 selects Y, 00 idle
//   cambio                 : one-cycle pulse on every selector change
//   ocupado                : high while selector is not 00
interface arbitro_selector_if;
    logic       solicitud1;
    logic       solicitud2;
    logic [1:0] selector;
    logic       cambio;
    logic       ocupado;
    modport master (output solicitud1, solicitud2, input selector, cambio, ocupado);
    modport slave  (input solicitud1, solicitud2, output selector, cambio, ocupado);
endinterface

// File: rtl/arbitro_selector.sv
// arbitro_selector: two-input round-robin arbiter driving a 2:1 mux select with bounded turns.
//   reloj    : clock, all state updates on the rising edge
//   reinicio : synchronous active-high reset
//   bus      : slave side of arbitro_selector_if (requests in; selector, cambio, ocupado out)
module arbitro_selector #(
    parameter int TURNO_MAX = 8
) (
    input logic               reloj,
    input logic               reinicio,
    arbitro_selector_if.slave bus
);
    typedef enum logic [1:0] {
        REPOSO   = 2'b00,
        CONCEDE1 = 2'b01,
        CONCEDE2 = 2'b10
    } estado_t;

    localparam logic [7:0] TOPE = 8'(TURNO_MAX - 1);

    estado_t    estado, estado_sig;
    logic [7:0] contador;
    logic       ultimo;
    logic       cambio_q, ocupado_q;

    wire s1 = bus.solicitud1;
    wire s2 = bus.solicitud2;

    // ultimo: 0 = input 1 granted last, 1 = input 2 granted last
    always_comb begin
        estado_sig = estado;
        case (estado)
            REPOSO:   estado_sig = (s1 && s2) ? (ultimo ? CONCEDE1 : CONCEDE2) :
                                   s1 ? CONCEDE1 : s2 ? CONCEDE2 : REPOSO;
            CONCEDE1: estado_sig = !s1 ? (s2 ? CONCEDE2 : REPOSO) :
                                   (s2 && contador == TOPE) ? CONCEDE2 : CONCEDE1;
            CONCEDE2: estado_sig = !s2 ? (s1 ? CONCEDE1 : REPOSO) :
                                   (s1 && contador == TOPE) ? CONCEDE1 : CONCEDE2;
            default:  estado_sig = REPOSO;
        endcase
    end

    // selector is the state itself, so cambio/ocupado are computed from the
    // next state to stay aligned with it
    always_ff @(posedge reloj) begin
        if (reinicio) begin
            estado    <= REPOSO;
            cambio_q  <= 1'b0;
            ocupado_q <= 1'b0;
            contador  <= 8'd0;
            ultimo    <= 1'b1;
        end else begin
            estado    <= estado_sig;
            cambio_q  <= estado_sig != estado;
            ocupado_q <= estado_sig != REPOSO;
            if (estado_sig != REPOSO && estado_sig != estado) begin
                contador <= 8'd0;
                ultimo   <= estado_sig == CONCEDE2;
            end else if (estado_sig != REPOSO && contador != TOPE) begin
                contador <= contador + 8'd1;
            end
        end
    end

    assign bus.selector = estado;
    assign bus.cambio   = cambio_q;
    assign bus.ocupado  = ocupado_q;
endmodule

// File: tb/tb_arbitro_selector.sv
// tb_arbitro_selector: directed and random checks of arbitro_selector with TURNO_MAX 8 and 1.
module tb_arbitro_selector;
    logic reloj = 1'b0;
    logic reinicio = 1'b1;
    int   checks = 0;
    int   failures = 0;

    arbitro_selector_if a ();
    arbitro_selector_if b ();

    arbitro_selector #(.TURNO_MAX(8)) u_a (.reloj(reloj), .reinicio(reinicio), .bus(a.slave));
    arbitro_selector #(.TURNO_MAX(1)) u_b (.reloj(reloj), .reinicio(reinicio), .bus(b.slave));

    always #5 reloj = ~reloj;

    task automatic tick;
        @(posedge reloj);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // stay counts edges a grant was kept while the other input requested
    task automatic rnd_chk(input string tag, input logic [1:0] sel, input logic cam, input logic ocu,
                           input logic [1:0] psel, input logic r1, input logic r2,
                           input int tope, inout int stay);
        if (sel != 2'b00 && sel == psel && (sel == 2'b01 ? r2 : r1)) stay++;
        else if (sel != psel) stay = 0;
        chk({tag, "_no11"}, {3'b0, sel == 2'b11}, 4'd0);
        chk({tag, "_ocupado"}, {3'b0, ocu}, {3'b0, |sel});
        chk({tag, "_cambio"}, {3'b0, cam}, {3'b0, sel != psel});
        chk({tag, "_turno"}, {3'b0, stay > tope - 1}, 4'd0);
    endtask

    initial begin
        logic [1:0] pa, pb;
        logic ra1, ra2, rb1, rb2;
        int sa, sb;
        a.solicitud1 = 1'b0; a.solicitud2 = 1'b0;
        b.solicitud1 = 1'b0; b.solicitud2 = 1'b0;
        tick; tick;
        chk("reset_a", {a.selector, a.cambio, a.ocupado}, 4'b0000);
        chk("reset_b", {b.selector, b.cambio, b.ocupado}, 4'b0000);
        reinicio = 1'b0;
        a.solicitud1 = 1'b1;
        tick;
        chk("s1_grant", {a.selector, a.cambio, a.ocupado}, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("s1_hold", {a.selector, a.cambio, a.ocupado}, 4'b0101);
        end
        chk("b_idle", {b.selector, b.cambio, b.ocupado}, 4'b0000);
        a.solicitud1 = 1'b0;
        tick;
        chk("s1_release", {a.selector, a.cambio, a.ocupado}, 4'b0010);
        tick;
        chk("s1_idle", {a.selector, a.cambio, a.ocupado}, 4'b0000);
        reinicio = 1'b1;
        tick;
        chk("reset2_a", {a.selector, a.cambio, a.ocupado}, 4'b0000);
        reinicio = 1'b0;
        a.solicitud1 = 1'b1; a.solicitud2 = 1'b1;
        b.solicitud1 = 1'b1; b.solicitud2 = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick;
            chk($sformatf("turn8_%0d", i), {a.selector, a.cambio, a.ocupado},
                {((i / 8) % 2 == 0) ? 2'b01 : 2'b10, i % 8 == 0, 1'b1});
            chk($sformatf("turn1_%0d", i), {b.selector, b.cambio, b.ocupado},
                {(i % 2 == 0) ? 2'b01 : 2'b10, 2'b11});
        end
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("g2_hold", {a.selector, a.cambio, a.ocupado}, 4'b1001);
        end
        a.solicitud2 = 1'b0;
        tick;
        chk("g2_drop", {a.selector, a.cambio, a.ocupado}, 4'b0111);
        a.solicitud2 = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick;
            chk($sformatf("reload_%0d", i), {a.selector, a.cambio, a.ocupado}, 4'b0101);
        end
        tick;
        chk("reload_switch", {a.selector, a.cambio, a.ocupado}, 4'b1011);
        reinicio = 1'b1;
        tick;
        chk("midreset_a", {a.selector, a.cambio, a.ocupado}, 4'b0000);
        chk("midreset_b", {b.selector, b.cambio, b.ocupado}, 4'b0000);
        reinicio = 1'b0;
        tick;
        chk("resume_a", {a.selector, a.cambio, a.ocupado}, 4'b0111);
        chk("resume_b", {b.selector, b.cambio, b.ocupado}, 4'b0111);
        a.solicitud1 = 1'b0;
        tick;
        chk("g1_to_g2", {a.selector, a.cambio, a.ocupado}, 4'b1011);
        a.solicitud2 = 1'b0;
        tick;
        chk("g2_idle", {a.selector, a.cambio, a.ocupado}, 4'b0010);
        a.solicitud2 = 1'b1;
        tick;
        chk("s2_alone", {a.selector, a.cambio, a.ocupado}, 4'b1011);
        a.solicitud2 = 1'b0;
        tick;
        chk("s2_idle", {a.selector, a.cambio, a.ocupado}, 4'b0010);
        a.solicitud1 = 1'b1; a.solicitud2 = 1'b1;
        tick;
        chk("tie_last2", {a.selector, a.cambio, a.ocupado}, 4'b0111);
        a.solicitud1 = 1'b0; a.solicitud2 = 1'b0;
        tick;
        chk("tie_idle", {a.selector, a.cambio, a.ocupado}, 4'b0010);
        a.solicitud1 = 1'b1; a.solicitud2 = 1'b1;
        tick;
        chk("tie_last1", {a.selector, a.cambio, a.ocupado}, 4'b1011);
        pa = a.selector; pb = b.selector;
        sa = 0; sb = 0;
        for (int i = 0; i < 10000; i++) begin
            ra1 = 1'($urandom_range(0, 1)); ra2 = 1'($urandom_range(0, 1));
            rb1 = 1'($urandom_range(0, 1)); rb2 = 1'($urandom_range(0, 1));
            a.solicitud1 = ra1; a.solicitud2 = ra2;
            b.solicitud1 = rb1; b.solicitud2 = rb2;
            tick;
            rnd_chk("rnd_a", a.selector, a.cambio, a.ocupado, pa, ra1, ra2, 8, sa);
            rnd_chk("rnd_b", b.selector, b.cambio, b.ocupado, pb, rb1, rb2, 1, sb);
            pa = a.selector; pb = b.selector;
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
